seg_scan_decoder: RTL

Monitor-side decoder for the multiplexed 4-digit 7-segment scan bus. It watches the `an`/`seg` lines produced by the calculator's display driver and reconstructs the 16-bit hex value being shown, or reports that the display is blanked with dashes. It is used as the self-check monitor in board-level benches and as the receiving end when one board's display bus is wired into another board's inputs.

---
 rtl/seg_scan_decoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Observer for the multiplexed 4-digit 7-segment scan bus.
// It rebuilds the 16-bit hex value from settled digit windows, or reports an all-dash blanked display.
module seg_scan_decoder #(
   parameter int unsigned SETTLE = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] num,
   output logic        disp_en,
   output logic        frame_valid,
   output logic        frame_err
);

   typedef enum logic [0:0] {HUNT = 1'b0, COLLECT = 1'b1} state_e;

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   // Returns {bad, dash, nibble} for an active-low segment pattern
   function automatic logic [5:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h40:   seg_decode = {2'b00, 4'h0};
         7'h79:   seg_decode = {2'b00, 4'h1};
         7'h24:   seg_decode = {2'b00, 4'h2};
         7'h30:   seg_decode = {2'b00, 4'h3};
         7'h19:   seg_decode = {2'b00, 4'h4};
         7'h12:   seg_decode = {2'b00, 4'h5};
         7'h02:   seg_decode = {2'b00, 4'h6};
         7'h78:   seg_decode = {2'b00, 4'h7};
         7'h00:   seg_decode = {2'b00, 4'h8};
         7'h10:   seg_decode = {2'b00, 4'h9};
         7'h08:   seg_decode = {2'b00, 4'hA};
         7'h03:   seg_decode = {2'b00, 4'hB};
         7'h27:   seg_decode = {2'b00, 4'hC};
         7'h21:   seg_decode = {2'b00, 4'hD};
         7'h06:   seg_decode = {2'b00, 4'hE};
         7'h0E:   seg_decode = {2'b00, 4'hF};
         7'h3F:   seg_decode = {2'b01, 4'h0};
         default: seg_decode = {2'b10, 4'h0};
      endcase
   endfunction

   logic [3:0]  an_m_q, an_s_q;
   logic [6:0]  seg_m_q, seg_s_q;
   logic [10:0] s_prev_q;
   logic [7:0]  r_q, r_d;
   logic        sample_q, sample_d;
   logic        onehot_s, changed_s;

   // Synchronizer, previous-word history and stability counter
   always_ff @(posedge clk) begin
      if (reset) begin
         an_m_q   <= 4'hF;
         an_s_q   <= 4'hF;
         seg_m_q  <= 7'h7F;
         seg_s_q  <= 7'h7F;
         s_prev_q <= 11'h7FF;
         r_q      <= 8'd0;
         sample_q <= 1'b0;
      end else begin
         an_m_q   <= an;
         an_s_q   <= an_m_q;
         seg_m_q  <= seg;
         seg_s_q  <= seg_m_q;
         s_prev_q <= {an_s_q, seg_s_q};
         r_q      <= r_d;
         sample_q <= sample_d;
      end
   end

   // Counter next state; a sample fires only on the first arrival at SETTLE
   always_comb begin
      onehot_s  = (an_s_q == 4'b1110) || (an_s_q == 4'b1101) ||
                  (an_s_q == 4'b1011) || (an_s_q == 4'b0111);
      changed_s = ({an_s_q, seg_s_q} != s_prev_q);
      r_d       = r_q;
      if (changed_s || !onehot_s) begin
         r_d = 8'd0;
      end else if (r_q < SETTLE_C) begin
         r_d = r_q + 8'd1;
      end else begin
         r_d = r_q;
      end
      sample_d = (r_d == SETTLE_C) && (r_q != SETTLE_C);
   end

   // s_prev_q holds the settled word during the sample cycle
   logic [1:0] idx_s;
   logic [5:0] dec_s;

   // Anode to digit index and segment decode of the settled word
   always_comb begin
      dec_s = seg_decode(s_prev_q[6:0]);
      case (s_prev_q[10:7])
         4'b1110: idx_s = 2'd0;
         4'b1101: idx_s = 2'd1;
         4'b1011: idx_s = 2'd2;
         4'b0111: idx_s = 2'd3;
         default: idx_s = 2'd0;
      endcase
   end

   state_e      state_q, state_d;
   logic [1:0]  nx_q, nx_d;
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  dash_q, dash_d;
   logic        bad_q, bad_d;
   logic [15:0] num_q, num_d;
   logic        disp_en_q, disp_en_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   // Frame state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HUNT;
         nx_q      <= 2'd0;
         shadow_q  <= 16'h0000;
         dash_q    <= 4'h0;
         bad_q     <= 1'b0;
         num_q     <= 16'h0000;
         disp_en_q <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         nx_q      <= nx_d;
         shadow_q  <= shadow_d;
         dash_q    <= dash_d;
         bad_q     <= bad_d;
         num_q     <= num_d;
         disp_en_q <= disp_en_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // Frame assembly: digit 0 always (re)starts, in-order digits accumulate, digit 3 publishes
   always_comb begin
      state_d   = state_q;
      nx_d      = nx_q;
      shadow_d  = shadow_q;
      dash_d    = dash_q;
      bad_d     = bad_q;
      num_d     = num_q;
      disp_en_d = disp_en_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      if (sample_q && (idx_s == 2'd0)) begin
         shadow_d = {12'h000, dec_s[3:0]};
         dash_d   = {3'b000, dec_s[4]};
         bad_d    = dec_s[5];
         nx_d     = 2'd1;
         state_d  = COLLECT;
      end else if (sample_q) begin
         case (state_q)
            HUNT: begin
               state_d = HUNT;
            end
            COLLECT: begin
               if (idx_s == nx_q) begin
                  shadow_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
                  dash_d[idx_s]                 = dec_s[4];
                  bad_d                         = bad_q | dec_s[5];
                  if (nx_q == 2'd3) begin
                     state_d = HUNT;
                     if (!bad_d && (dash_d == 4'h0)) begin
                        num_d     = shadow_d;
                        disp_en_d = 1'b1;
                        valid_d   = 1'b1;
                     end else if (!bad_d && (dash_d == 4'hF)) begin
                        num_d     = 16'h0000;
                        disp_en_d = 1'b0;
                        valid_d   = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end else begin
                     nx_d = nx_q + 2'd1;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign num         = num_q;
   assign disp_en     = disp_en_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;

endmodule
